// File: rtl/axis_packet_dispatcher_multiplexeur.sv
// Merges the analysed (header) and remain (payload) branches of a packet back into one
// AXI-Stream: all analysed beats first, then all remain beats, through a registered output with a skid slot.
module axis_packet_dispatcher_multiplexeur #(
  parameter int AXIS_DATA_WIDTH    = 64,
  parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH    = 2,
  parameter int STATE_WIDTH        = 3,
  parameter int IDLE               = 0,
  parameter int SEND_ANALYSED_DATA = 3,
  parameter int SEND_REMAIN        = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_analysed_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_analysed_tkeep,
  input  logic                       s_axis_analysed_tvalid,
  output logic                       s_axis_analysed_tready,
  input  logic                       s_axis_analysed_tlast,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_analysed_tdest,
  input  logic                       s_axis_analysed_tuser,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_remain_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_remain_tkeep,
  input  logic                       s_axis_remain_tvalid,
  output logic                       s_axis_remain_tready,
  input  logic                       s_axis_remain_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
  output logic [STATE_WIDTH-1:0]     state
);

  // Handshakes: a beat transfers on a rising clk edge where tvalid and tready are both 1;
  // tvalid never waits on tready, and a held beat keeps its payload stable until it transfers.

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = STATE_WIDTH'(IDLE),
    ST_ANALYSED = STATE_WIDTH'(SEND_ANALYSED_DATA),
    ST_REMAIN   = STATE_WIDTH'(SEND_REMAIN)
  } state_t;

  state_t                     state_q, state_d;
  logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;

  logic                       skid_valid;
  logic [AXIS_DATA_WIDTH-1:0] skid_data;
  logic [AXIS_KEEP_WIDTH-1:0] skid_keep;
  logic                       skid_last;
  logic [AXIS_DEST_WIDTH-1:0] skid_dest;

  logic                       int_ready, ana_acc, rem_acc, in_valid, in_last;
  logic [AXIS_DATA_WIDTH-1:0] in_data;
  logic [AXIS_KEEP_WIDTH-1:0] in_keep;
  logic [AXIS_DEST_WIDTH-1:0] in_dest;

  assign int_ready = !skid_valid;
  assign s_axis_analysed_tready = int_ready && (state_q == ST_IDLE || state_q == ST_ANALYSED);
  assign s_axis_remain_tready   = int_ready && (state_q == ST_REMAIN);
  assign ana_acc = s_axis_analysed_tvalid && s_axis_analysed_tready;
  assign rem_acc = s_axis_remain_tvalid && s_axis_remain_tready;
  assign state   = state_q;

  // The merged packet ends on the analysed side only when there is no remain part.
  assign in_valid = ana_acc || rem_acc;
  assign in_data  = rem_acc ? s_axis_remain_tdata : s_axis_analysed_tdata;
  assign in_keep  = rem_acc ? s_axis_remain_tkeep : s_axis_analysed_tkeep;
  assign in_last  = rem_acc ? s_axis_remain_tlast
                            : (s_axis_analysed_tlast && s_axis_analysed_tuser);
  assign in_dest  = (state_q == ST_IDLE) ? s_axis_analysed_tdest : dest_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (ana_acc) begin
          dest_d = s_axis_analysed_tdest;
          if (!s_axis_analysed_tlast)     state_d = ST_ANALYSED;
          else if (!s_axis_analysed_tuser) state_d = ST_REMAIN;
        end
      end
      ST_ANALYSED: begin
        if (ana_acc && s_axis_analysed_tlast)
          state_d = s_axis_analysed_tuser ? ST_IDLE : ST_REMAIN;
      end
      ST_REMAIN: begin
        if (rem_acc && s_axis_remain_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  // Output register is loaded from skid first so beat order is preserved.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_last     <= 1'b0;
      skid_dest     <= '0;
    end else if (!m_axis_tvalid || m_axis_tready) begin
      if (skid_valid) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= skid_data;
        m_axis_tkeep  <= skid_keep;
        m_axis_tlast  <= skid_last;
        m_axis_tdest  <= skid_dest;
        skid_valid    <= 1'b0;
      end else begin
        m_axis_tvalid <= in_valid;
        if (in_valid) begin
          m_axis_tdata <= in_data;
          m_axis_tkeep <= in_keep;
          m_axis_tlast <= in_last;
          m_axis_tdest <= in_dest;
        end
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_keep  <= in_keep;
      skid_last  <= in_last;
      skid_dest  <= in_dest;
    end
  end

endmodule

// File: tb/tb_axis_packet_dispatcher_multiplexeur.sv
// Bench for the analysed/remain packet merger: scoreboarded merged output plus
// readiness, backpressure, stability and mid-packet reset scenarios.
module tb_axis_packet_dispatcher_multiplexeur;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int DSTW = 2;
  localparam int EW = DSTW + 1 + KW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   s_axis_analysed_tdata = '0;
  logic [KW-1:0]   s_axis_analysed_tkeep = '0;
  logic            s_axis_analysed_tvalid = 1'b0;
  logic            s_axis_analysed_tready;
  logic            s_axis_analysed_tlast = 1'b0;
  logic [DSTW-1:0] s_axis_analysed_tdest = '0;
  logic            s_axis_analysed_tuser = 1'b0;
  logic [DW-1:0]   s_axis_remain_tdata = '0;
  logic [KW-1:0]   s_axis_remain_tkeep = '0;
  logic            s_axis_remain_tvalid = 1'b0;
  logic            s_axis_remain_tready;
  logic            s_axis_remain_tlast = 1'b0;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            m_axis_tlast;
  logic [DSTW-1:0] m_axis_tdest;
  logic [2:0]      state;

  axis_packet_dispatcher_multiplexeur dut (
    .clk(clk), .rst(rst),
    .s_axis_analysed_tdata(s_axis_analysed_tdata), .s_axis_analysed_tkeep(s_axis_analysed_tkeep),
    .s_axis_analysed_tvalid(s_axis_analysed_tvalid), .s_axis_analysed_tready(s_axis_analysed_tready),
    .s_axis_analysed_tlast(s_axis_analysed_tlast), .s_axis_analysed_tdest(s_axis_analysed_tdest),
    .s_axis_analysed_tuser(s_axis_analysed_tuser),
    .s_axis_remain_tdata(s_axis_remain_tdata), .s_axis_remain_tkeep(s_axis_remain_tkeep),
    .s_axis_remain_tvalid(s_axis_remain_tvalid), .s_axis_remain_tready(s_axis_remain_tready),
    .s_axis_remain_tlast(s_axis_remain_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .state(state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_out_cyc = -1;
  int max_gap = 0;
  bit no_rem_window = 1'b0;
  bit ana_pending = 1'b0;
  int rem_rdy_cnt = 0;
  bit hold_valid = 1'b0;
  logic [EW-1:0] held;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                         input logic l, input logic [DSTW-1:0] dst);
    return {dst, l, k, d};
  endfunction

  task automatic push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic l, input logic [DSTW-1:0] dst);
    exp_q.push_back(pack(d, k, l, dst));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    cur = pack(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest);
    if (rst) begin
      hold_valid = 1'b0;
    end else begin
      if ((no_rem_window || ana_pending) && s_axis_remain_tready) rem_rdy_cnt++;
      if (hold_valid && m_axis_tvalid) check("hold_stable", cur, held);
      hold_valid = m_axis_tvalid && !m_axis_tready;
      held = cur;
      if (m_axis_tvalid && m_axis_tready) begin
        check("queue_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_beat", cur, e);
        end
        if (last_out_cyc >= 0 && cyc - last_out_cyc > max_gap) max_gap = cyc - last_out_cyc;
        last_out_cyc = cyc;
      end
    end
  end

  // Drivers: inputs change #1 after the edge, ready is sampled on the preceding negedge
  task automatic send_ana(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                          input logic u, input logic [DSTW-1:0] dst);
    bit acc = 1'b0;
    s_axis_analysed_tdata = d;
    s_axis_analysed_tkeep = k;
    s_axis_analysed_tlast = l;
    s_axis_analysed_tuser = u;
    s_axis_analysed_tdest = dst;
    s_axis_analysed_tvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_axis_analysed_tready;
      @(posedge clk);
      #1;
    end
    check("ana_accept", acc, 1);
    s_axis_analysed_tvalid = 1'b0;
  endtask

  task automatic send_rem(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit acc = 1'b0;
    s_axis_remain_tdata = d;
    s_axis_remain_tkeep = k;
    s_axis_remain_tlast = l;
    s_axis_remain_tvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = s_axis_remain_tready;
      @(posedge clk);
      #1;
    end
    check("rem_accept", acc, 1);
    s_axis_remain_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drained", exp_q.size(), 0);
  endtask

  task automatic run_basic(input bit bp);
    push_exp(64'hA0, 8'hFF, 1'b0, 2'd2);
    push_exp(64'hA1, 8'hFF, 1'b0, 2'd2);
    push_exp(64'hB0, 8'hFF, 1'b0, 2'd2);
    push_exp(64'hB1, 8'hFF, 1'b0, 2'd2);
    push_exp(64'hB2, 8'h0F, 1'b1, 2'd2);
    last_out_cyc = -1;
    max_gap = 0;
    fork
      begin
        send_ana(64'hA0, 8'hFF, 1'b0, 1'b0, 2'd2);
        send_ana(64'hA1, 8'hFF, 1'b1, 1'b0, 2'd2);
      end
      begin
        send_rem(64'hB0, 8'hFF, 1'b0);
        send_rem(64'hB1, 8'hFF, 1'b0);
        send_rem(64'hB2, 8'h0F, 1'b1);
      end
      begin
        if (bp) begin
          m_axis_tready = 1'b0;
          repeat (5) @(posedge clk);
          #1;
          check("bp_ana_ready", s_axis_analysed_tready, 0);
          check("bp_rem_ready", s_axis_remain_tready, 0);
          check("bp_valid", m_axis_tvalid, 1);
          check("bp_head", m_axis_tdata, 64'hA0);
          check("bp_state", state, 3'd4);
          m_axis_tready = 1'b1;
        end
      end
    join
    wait_drain();
    check("basic_state_idle", state, 3'd0);
    if (!bp) check("basic_gap", max_gap, 1);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_valid", m_axis_tvalid, 0);
    check("rst_data", m_axis_tdata, 0);
    check("rst_keep", m_axis_tkeep, 0);
    check("rst_last", m_axis_tlast, 0);
    check("rst_dest", m_axis_tdest, 0);
    check("rst_ana_ready", s_axis_analysed_tready, 1);
    check("rst_rem_ready", s_axis_remain_tready, 0);

    // Basic merge
    run_basic(1'b0);

    // Header-only packet
    push_exp(64'hC0, 8'hFF, 1'b1, 2'd1);
    rem_rdy_cnt = 0;
    no_rem_window = 1'b1;
    send_ana(64'hC0, 8'hFF, 1'b1, 1'b1, 2'd1);
    check("hdr_state", state, 3'd0);
    wait_drain();
    no_rem_window = 1'b0;
    check("hdr_rem_ready", rem_rdy_cnt, 0);

    // Early remain, with a zero-keep payload beat
    push_exp(64'hE0, 8'h3F, 1'b0, 2'd0);
    push_exp(64'hD0, 8'h00, 1'b1, 2'd0);
    rem_rdy_cnt = 0;
    ana_pending = 1'b1;
    fork
      send_rem(64'hD0, 8'h00, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_ana(64'hE0, 8'h3F, 1'b1, 1'b0, 2'd0);
        ana_pending = 1'b0;
      end
    join
    wait_drain();
    check("early_rem_ready", rem_rdy_cnt, 0);

    // Backpressure during basic merge
    run_basic(1'b1);

    // Back-to-back packets
    push_exp(64'h31, 8'hFF, 1'b0, 2'd3);
    push_exp(64'h32, 8'hFF, 1'b1, 2'd3);
    push_exp(64'h41, 8'hFF, 1'b0, 2'd0);
    push_exp(64'h42, 8'h01, 1'b1, 2'd0);
    last_out_cyc = -1;
    max_gap = 0;
    fork
      begin
        send_ana(64'h31, 8'hFF, 1'b1, 1'b0, 2'd3);
        send_ana(64'h41, 8'hFF, 1'b1, 1'b0, 2'd0);
      end
      begin
        send_rem(64'h32, 8'hFF, 1'b1);
        send_rem(64'h42, 8'h01, 1'b1);
      end
    join
    wait_drain();
    check("b2b_gap", max_gap, 1);

    // Random-payload merges
    for (int p = 0; p < 4; p++) begin
      logic [DW-1:0] d0, d1;
      logic [DSTW-1:0] dst;
      d0 = {$urandom(), $urandom()};
      d1 = {$urandom(), $urandom()};
      dst = DSTW'($urandom_range(0, 3));
      push_exp(d0, 8'hFF, 1'b0, dst);
      push_exp(d1, 8'hF0, 1'b1, dst);
      fork
        send_ana(d0, 8'hFF, 1'b1, 1'b0, dst);
        send_rem(d1, 8'hF0, 1'b1);
      join
    end
    wait_drain();

    // Reset mid-packet with two beats buffered
    m_axis_tready = 1'b0;
    fork
      send_ana(64'hF0, 8'hFF, 1'b1, 1'b0, 2'd1);
      send_rem(64'hF1, 8'hFF, 1'b0);
    join
    check("mid_state", state, 3'd4);
    check("mid_ana_ready", s_axis_analysed_tready, 0);
    check("mid_rem_ready", s_axis_remain_tready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", m_axis_tvalid, 0);
    check("mid_rst_state", state, 3'd0);
    m_axis_tready = 1'b1;
    run_basic(1'b0);

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_dispatcher_multiplexeur.md
Name: axis_packet_dispatcher_multiplexeur

Overview:
- Recombines the two branches of the packet dispatcher into one AXI-Stream output, after the demultiplexer has split them.
- The analysed branch carries header words emitted by the parser/analyser; the remain branch carries the untouched payload words.
- Each packet is output as all analysed beats followed by all remain beats, with a registered output and a skid buffer for full throughput.
- Sits between the parser/analyser plus passthrough path and the downstream scheduler/egress.

Parameters:
- AXIS_DATA_WIDTH, 64, data width of all streams.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, byte-enable width.
- AXIS_DEST_WIDTH, 2, tdest width.
- STATE_WIDTH, 3, state encoding width.
- IDLE, 0, state code.
- SEND_ANALYSED_DATA, 3, state code.
- SEND_REMAIN, 4, state code.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_analysed_tdata  in  AXIS_DATA_WIDTH  analysed header word.
- s_axis_analysed_tkeep  in  AXIS_KEEP_WIDTH  byte enables.
- s_axis_analysed_tvalid  in  1  valid.
- s_axis_analysed_tready  out  1  ready.
- s_axis_analysed_tlast  in  1  last analysed beat of the packet.
- s_axis_analysed_tdest  in  AXIS_DEST_WIDTH  destination; sampled on the first beat only.
- s_axis_analysed_tuser  in  1  on a tlast beat, 1 = packet has no remain part.
- s_axis_remain_tdata  in  AXIS_DATA_WIDTH  payload word.
- s_axis_remain_tkeep  in  AXIS_KEEP_WIDTH  byte enables.
- s_axis_remain_tvalid  in  1  valid.
- s_axis_remain_tready  out  1  ready.
- s_axis_remain_tlast  in  1  end of packet.
- m_axis_tdata  out  AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  AXIS_KEEP_WIDTH  merged byte enables.
- m_axis_tvalid  out  1  valid.
- m_axis_tready  in  1  ready.
- m_axis_tlast  out  1  end of merged packet.
- m_axis_tdest  out  AXIS_DEST_WIDTH  latched destination of the packet.
- state  out  STATE_WIDTH  current FSM state, for observation and sync.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - Output register and skid register invalid; m_axis_tvalid=0.
  - m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tdest registers = 0.
  - Latched tdest = 0.
- Reset mid-packet: abandons the packet with no flush; stale beats must be dropped upstream.
- Input acceptance:
  - Common ready `int_ready` = skid register empty.
  - s_axis_analysed_tready = int_ready when state is IDLE or SEND_ANALYSED_DATA, else 0.
  - s_axis_remain_tready = int_ready when state is SEND_REMAIN, else 0.
  - The non-selected branch never sees ready.
- FSM transitions, evaluated on an accepted beat:
  - IDLE + analysed beat: latch tdest.
    - If tlast=1 and tuser=1: stay IDLE.
    - If tlast=1 and tuser=0: go to SEND_REMAIN.
    - If tlast=0: go to SEND_ANALYSED_DATA.
  - SEND_ANALYSED_DATA + analysed beat with tlast=1: go to IDLE if tuser=1, else to SEND_REMAIN. tdest is not re-sampled.
  - SEND_REMAIN + remain beat with tlast=1: go to IDLE.
  - No accepted beat: hold state.
- Output tlast:
  - On an analysed beat: 1 only if tlast=1 and tuser=1, else 0.
  - On a remain beat: copies remain tlast.
- Output tdest: the latched value of the packet. On the first beat, the incoming tdest is used directly in the same cycle.
- Pipeline:
  - Accepted beat goes to the output register if it is empty or being consumed (m_axis_tready=1); otherwise it goes to the skid register.
  - When the output register drains and skid is valid, skid moves into the output register.
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
  - Sustained throughput is 1 beat/cycle when m_axis_tready=1.
  - Beat order is never altered; no beat is duplicated or lost.
- Backpressure: with m_axis_tready=0, at most 2 beats are buffered, then both input readies deassert.
- tkeep passes through unchanged. Zero-valued tkeep beats are forwarded as-is.
- Output stability: m_axis_tdata, m_axis_tkeep, m_axis_tlast and m_axis_tdest are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous valid on both branches: only the branch selected by state is accepted; the other waits.
- Remain data arriving early, while in IDLE or SEND_ANALYSED_DATA: is held off (ready=0) until SEND_REMAIN.

Test Plan:
- Basic merge:
  - Stimulus: 2 analysed beats (0xA0, 0xA1; tlast on 0xA1, tuser=0, tdest=2), then 3 remain beats (0xB0, 0xB1, 0xB2; tlast on 0xB2); m_axis_tready=1.
  - Response: output 0xA0, 0xA1, 0xB0, 0xB1, 0xB2 on consecutive cycles; tlast only on 0xB2; tdest=2 on all beats; state returns to IDLE.
- Header-only packet:
  - Stimulus: 1 analysed beat 0xC0 with tlast=1, tuser=1, tdest=1.
  - Response: single output beat with tlast=1 and tdest=1; remain tready never asserted; state stays IDLE.
- Early remain:
  - Stimulus: remain tvalid held high with 0xD0 from cycle 0; analysed beat 0xE0 (tlast=1, tuser=0) arrives at cycle 3.
  - Response: remain tready=0 until after 0xE0 is accepted; output order 0xE0 then 0xD0.
- Backpressure:
  - Stimulus: m_axis_tready=0 for 5 cycles during the basic merge.
  - Response: exactly 2 beats buffered, both readies low, outputs held stable; after release all 5 beats emerge in order, none lost.
- Back-to-back packets:
  - Stimulus: packet with tdest=3 immediately followed by packet with tdest=0.
  - Response: no idle cycles between packets; tdest switches exactly at the first beat of the second packet.
- Reset mid-packet:
  - Stimulus: assert rst while in SEND_REMAIN with 2 beats buffered.
  - Response: next cycle m_axis_tvalid=0 and state=IDLE; the following new packet merges correctly.
